// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    MG1,
    MG2,
    MY,
    WALK,
    SG,
    SY
  } state_t;

  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;

  localparam logic [3:0] DEF_BASE = 4'd6;
  localparam logic [3:0] DEF_EXT  = 4'd3;
  localparam logic [3:0] DEF_YEL  = 4'd2;

  typedef struct packed {
    logic rm;
    logic ym;
    logic gm;
    logic rs;
    logic ys;
    logic gs;
    logic w;
  } lamps_t;

  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t l;
    l = '0;
    case (s)
      MG1, MG2: begin
        l.gm = 1'b1;
        l.rs = 1'b1;
      end
      MY: begin
        l.ym = 1'b1;
        l.rs = 1'b1;
      end
      WALK: begin
        l.rm = 1'b1;
        l.rs = 1'b1;
        l.w  = 1'b1;
      end
      SG: begin
        l.rm = 1'b1;
        l.gs = 1'b1;
      end
      SY: begin
        l.rm = 1'b1;
        l.ys = 1'b1;
      end
      default: begin
        l.gm = 1'b1;
        l.rs = 1'b1;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Free-running timebase divider plus the 4-bit loadable phase down-counter.
module tick_timer import traffic_pkg::*; #(
  parameter int unsigned TICK_DIV    = 1,
  parameter logic [3:0]  RESET_COUNT = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       tick,
  output logic       expired
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div;
  logic [3:0]    count;

  assign tick    = (div == DIV_LAST);
  assign expired = tick && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (clear || tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Load has priority so an expiring phase reloads instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_COUNT;
    end else if (load) begin
      count <= load_value;
    end else if (tick) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/traffic_controller.sv
// Two-road intersection light controller: Moore FSM, timing registers and walk latch.
module traffic_controller import traffic_pkg::*; #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walkRequest,
  input  logic       reprogram,
  input  logic [1:0] extTimeSelector,
  input  logic [3:0] extTimeValue,
  output logic       Rm,
  output logic       Ym,
  output logic       Gm,
  output logic       Rs,
  output logic       Ys,
  output logic       Gs,
  output logic       W
);

  state_t     state, state_n;
  logic       sg_ext, sg_ext_n;
  logic       walk_latch;
  logic       enter_walk;
  logic [3:0] t_base, t_ext, t_yel;
  logic [3:0] t_base_n, t_ext_n, t_yel_n;
  logic [3:0] load_value;
  logic       tick, expired, advance, load;
  lamps_t     lamps;

  always_comb begin
    t_base_n = t_base;
    t_ext_n  = t_ext;
    t_yel_n  = t_yel;
    if (reprogram && (extTimeValue != '0)) begin
      case (extTimeSelector)
        SEL_BASE: t_base_n = extTimeValue;
        SEL_EXT:  t_ext_n  = extTimeValue;
        SEL_YEL:  t_yel_n  = extTimeValue;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_base <= DEF_BASE;
      t_ext  <= DEF_EXT;
      t_yel  <= DEF_YEL;
    end else begin
      t_base <= t_base_n;
      t_ext  <= t_ext_n;
      t_yel  <= t_yel_n;
    end
  end

  assign advance = tick && expired;
  assign load    = reprogram || advance;

  // Reprogram restarts MG1 with the value being written this same cycle.
  always_comb begin
    state_n    = state;
    sg_ext_n   = sg_ext;
    enter_walk = 1'b0;
    load_value = t_base - 4'd1;
    if (reprogram) begin
      state_n    = MG1;
      sg_ext_n   = 1'b0;
      load_value = t_base_n - 4'd1;
    end else if (advance) begin
      case (state)
        MG1: begin
          state_n    = MG2;
          load_value = (sensor ? t_ext : t_base) - 4'd1;
        end
        MG2: begin
          state_n    = MY;
          load_value = t_yel - 4'd1;
        end
        MY: begin
          if (walk_latch) begin
            state_n    = WALK;
            enter_walk = 1'b1;
            load_value = t_ext - 4'd1;
          end else begin
            state_n    = SG;
            load_value = t_base - 4'd1;
          end
        end
        WALK: begin
          state_n    = SG;
          load_value = t_base - 4'd1;
        end
        SG: begin
          if (!sg_ext && sensor) begin
            sg_ext_n   = 1'b1;
            load_value = t_ext - 4'd1;
          end else begin
            state_n    = SY;
            sg_ext_n   = 1'b0;
            load_value = t_yel - 4'd1;
          end
        end
        SY: begin
          state_n    = MG1;
          load_value = t_base - 4'd1;
        end
        default: begin
          state_n    = MG1;
          load_value = t_base - 4'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= MG1;
      sg_ext     <= 1'b0;
      walk_latch <= 1'b0;
    end else begin
      state      <= state_n;
      sg_ext     <= sg_ext_n;
      walk_latch <= walkRequest || (walk_latch && !enter_walk);
    end
  end

  tick_timer #(
    .TICK_DIV   (TICK_DIV),
    .RESET_COUNT(DEF_BASE - 4'd1)
  ) u_tick_timer (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (reprogram),
    .load      (load),
    .load_value(load_value),
    .tick      (tick),
    .expired   (expired)
  );

  assign lamps = decode_lamps(state);
  assign Rm    = lamps.rm;
  assign Ym    = lamps.ym;
  assign Gm    = lamps.gm;
  assign Rs    = lamps.rs;
  assign Ys    = lamps.ys;
  assign Gs    = lamps.gs;
  assign W     = lamps.w;

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: two instances (TICK_DIV 1 and 4) against a phase-duration model.
module tb_traffic_controller;

  localparam int P_MG1 = 0, P_MG2 = 1, P_MY = 2, P_WALK = 3, P_SG = 4, P_SY = 5;
  localparam int B_RM = 6, B_YM = 5, B_GM = 4, B_RS = 3, B_YS = 2, B_GS = 1, B_W = 0;

  logic       clk;
  logic       reset;
  logic       sensor;
  logic       walkRequest;
  logic       reprogram;
  logic [1:0] extTimeSelector;
  logic [3:0] extTimeValue;
  logic       Rm1, Ym1, Gm1, Rs1, Ys1, Gs1, W1;
  logic       Rm4, Ym4, Gm4, Rs4, Ys4, Gs4, W4;
  logic [6:0] l1, l4;

  int checks;
  int errors;

  int tb_b, tb_e, tb_y;
  int m_phase [2];
  int m_rem   [2];
  int m_ext   [2];
  int m_walk  [2];

  traffic_controller #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .sensor(sensor), .walkRequest(walkRequest),
    .reprogram(reprogram), .extTimeSelector(extTimeSelector), .extTimeValue(extTimeValue),
    .Rm(Rm1), .Ym(Ym1), .Gm(Gm1), .Rs(Rs1), .Ys(Ys1), .Gs(Gs1), .W(W1)
  );

  traffic_controller #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .sensor(sensor), .walkRequest(walkRequest),
    .reprogram(reprogram), .extTimeSelector(extTimeSelector), .extTimeValue(extTimeValue),
    .Rm(Rm4), .Ym(Ym4), .Gm(Gm4), .Rs(Rs4), .Ys(Ys4), .Gs(Gs4), .W(W4)
  );

  assign l1 = {Rm1, Ym1, Gm1, Rs1, Ys1, Gs1, W1};
  assign l4 = {Rm4, Ym4, Gm4, Rs4, Ys4, Gs4, W4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Lamp vector {Rm,Ym,Gm,Rs,Ys,Gs,W} for each phase.
  function automatic logic [6:0] exp_lamps(input int p);
    case (p)
      P_MG1, P_MG2: return 7'b0011000;
      P_MY:         return 7'b0101000;
      P_WALK:       return 7'b1001001;
      P_SG:         return 7'b1000010;
      P_SY:         return 7'b1000100;
      default:      return 7'b0000000;
    endcase
  endfunction

  // Model: each phase lasts (duration * TICK_DIV) clocks; decisions made on the clock that ends a phase.
  task automatic model_edge();
    int nw;
    int d;
    if (!reset) begin
      tb_b = 6; tb_e = 3; tb_y = 2;
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = P_MG1; m_rem[k] = 6 * div_of(k); m_ext[k] = 0; m_walk[k] = 0;
      end
      return;
    end
    if (reprogram && extTimeSelector != 2'd3 && extTimeValue != 4'd0) begin
      if (extTimeSelector == 2'd0) tb_b = int'(extTimeValue);
      else if (extTimeSelector == 2'd1) tb_e = int'(extTimeValue);
      else tb_y = int'(extTimeValue);
    end
    for (int k = 0; k < 2; k++) begin
      d  = div_of(k);
      nw = m_walk[k];
      if (reprogram) begin
        m_phase[k] = P_MG1; m_rem[k] = tb_b * d; m_ext[k] = 0;
      end else begin
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) begin
          case (m_phase[k])
            P_MG1: begin m_phase[k] = P_MG2; m_rem[k] = (sensor ? tb_e : tb_b) * d; end
            P_MG2: begin m_phase[k] = P_MY; m_rem[k] = tb_y * d; end
            P_MY: begin
              if (m_walk[k] != 0) begin m_phase[k] = P_WALK; m_rem[k] = tb_e * d; nw = 0; end
              else begin m_phase[k] = P_SG; m_rem[k] = tb_b * d; end
            end
            P_WALK: begin m_phase[k] = P_SG; m_rem[k] = tb_b * d; end
            P_SG: begin
              if (m_ext[k] == 0 && sensor) begin m_ext[k] = 1; m_rem[k] = tb_e * d; end
              else begin m_phase[k] = P_SY; m_ext[k] = 0; m_rem[k] = tb_y * d; end
            end
            default: begin m_phase[k] = P_MG1; m_rem[k] = tb_b * d; end
          endcase
        end
      end
      m_walk[k] = (nw != 0 || walkRequest) ? 1 : 0;
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (l1 === exp_lamps(m_phase[0])) else begin
      errors++;
      $error("FAIL lamps_div1 observed=%b expected=%b", l1, exp_lamps(m_phase[0]));
    end
    checks++;
    assert (l4 === exp_lamps(m_phase[1])) else begin
      errors++;
      $error("FAIL lamps_div4 observed=%b expected=%b", l4, exp_lamps(m_phase[1]));
    end
    checks++;
    assert ($onehot({Rm1, Ym1, Gm1}) && $onehot({Rs1, Ys1, Gs1}) &&
            $onehot({Rm4, Ym4, Gm4}) && $onehot({Rs4, Ys4, Gs4})) else begin
      errors++;
      $error("FAIL lamp_invariant observed div1=%b div4=%b expected one-hot per road", l1, l4);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Counts consecutive sampled cycles with lamp bit b high on instance k.
  task automatic chk_len(input string tag, input int k, input int b, input int want);
    logic [6:0] v;
    int n;
    n = 0;
    v = (k == 0) ? l1 : l4;
    while (v[b] && n < 400) begin
      cycle();
      n++;
      v = (k == 0) ? l1 : l4;
    end
    checks++;
    assert (n === want) else begin
      errors++;
      $error("FAIL %s observed=%0d cycles expected=%0d cycles", tag, n, want);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    sensor = 1'b0;
    walkRequest = 1'b0;
    reprogram = 1'b0;
    extTimeSelector = 2'd0;
    extTimeValue = 4'd0;

    cycle();
    cycle();
    checks++;
    assert (l1 === 7'b0011000 && l4 === 7'b0011000) else begin
      errors++;
      $error("FAIL reset_state observed div1=%b div4=%b expected=0011000", l1, l4);
    end
    reset = 1'b1;

    // Default sequence
    chk_len("default_main_green", 0, B_GM, 12);
    chk_len("default_main_yellow", 0, B_YM, 2);
    chk_len("default_side_green", 0, B_GS, 6);
    chk_len("default_side_yellow", 0, B_YS, 2);
    checks++;
    assert (Gm1 === 1'b1) else begin
      errors++;
      $error("FAIL default_wrap observed Gm=%b expected=1", Gm1);
    end

    // Sensor held high
    sensor = 1'b1;
    chk_len("sensor_main_green", 0, B_GM, 9);
    chk_len("sensor_main_yellow", 0, B_YM, 2);
    chk_len("sensor_side_green", 0, B_GS, 9);
    chk_len("sensor_side_yellow", 0, B_YS, 2);
    sensor = 1'b0;

    // Walk request pulsed in MG1
    walkRequest = 1'b1;
    cycle();
    walkRequest = 1'b0;
    chk_len("walk_main_green_rest", 0, B_GM, 11);
    chk_len("walk_main_yellow", 0, B_YM, 2);
    chk_len("walk_lamp", 0, B_W, 3);
    chk_len("walk_side_green", 0, B_GS, 6);
    chk_len("walk_side_yellow", 0, B_YS, 2);
    chk_len("nowalk_main_green", 0, B_GM, 12);
    chk_len("nowalk_main_yellow", 0, B_YM, 2);
    chk_len("nowalk_side_green", 0, B_GS, 6);
    chk_len("nowalk_side_yellow", 0, B_YS, 2);

    // Reprogram tBASE=4 then tYEL=1
    reprogram = 1'b1; extTimeSelector = 2'd0; extTimeValue = 4'd4;
    cycle();
    extTimeSelector = 2'd2; extTimeValue = 4'd1;
    cycle();
    reprogram = 1'b0;
    chk_len("reprog_main_green", 0, B_GM, 8);
    chk_len("reprog_main_yellow", 0, B_YM, 1);
    chk_len("reprog_side_green", 0, B_GS, 4);
    chk_len("reprog_side_yellow", 0, B_YS, 1);

    // Ignored writes: value 0, selector 11
    reprogram = 1'b1; extTimeSelector = 2'd0; extTimeValue = 4'd0;
    cycle();
    extTimeSelector = 2'd3; extTimeValue = 4'd9;
    cycle();
    reprogram = 1'b0;
    chk_len("ignored_main_green", 0, B_GM, 8);
    chk_len("ignored_main_yellow", 0, B_YM, 1);

    // Asynchronous reset in the middle of SG, with the walk latch set
    cycle();
    walkRequest = 1'b1;
    cycle();
    walkRequest = 1'b0;
    checks++;
    assert (Gs1 === 1'b1) else begin
      errors++;
      $error("FAIL mid_sg_setup observed Gs=%b expected=1", Gs1);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    assert (l1 === 7'b0011000 && l4 === 7'b0011000) else begin
      errors++;
      $error("FAIL async_reset observed div1=%b div4=%b expected=0011000", l1, l4);
    end
    cycle();
    cycle();
    reset = 1'b1;
    chk_len("post_reset_main_green", 0, B_GM, 12);
    chk_len("post_reset_main_yellow", 0, B_YM, 2);
    chk_len("post_reset_side_green", 0, B_GS, 6);

    // Divider scaling on the TICK_DIV=4 instance
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk_len("div4_main_green", 1, B_GM, 48);
    chk_len("div4_main_yellow", 1, B_YM, 8);
    chk_len("div4_side_green", 1, B_GS, 24);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      sensor          = ($urandom_range(0, 1) == 1);
      walkRequest     = ($urandom_range(0, 19) == 0);
      reprogram       = ($urandom_range(0, 99) == 0);
      extTimeSelector = 2'($urandom_range(0, 3));
      extTimeValue    = 4'($urandom_range(0, 15));
      reset           = ($urandom_range(0, 399) != 0);
      cycle();
    end
    reset = 1'b1;
    sensor = 1'b0;
    walkRequest = 1'b0;
    reprogram = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_controller.md
# traffic_controller

Two-road intersection light controller: a main road (m), a side road (s) and a pedestrian walk lamp (W). A Moore state machine sequences the lamps using three field-programmable durations (base, extend, yellow) counted in timebase ticks. A side-road vehicle sensor lengthens green phases, and a latched walk request inserts an all-red walk phase. The block sits at the top of the intersection design and drives the lamp outputs directly.

## Interface
- TICK_DIV, default 1: clock cycles per timebase tick (1 means one tick per clock; the board build sets it to the clock frequency in Hz).
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset; the port keeps the name `reset`.
- sensor  in  1  side-road vehicle present, level-sensitive, already synchronous.
- walkRequest  in  1  pedestrian button; any cycle it is high sets the walk latch.
- reprogram  in  1  write strobe for the timing registers.
- extTimeSelector  in  2  register select: 00 tBASE, 01 tEXT, 10 tYEL, 11 none.
- extTimeValue  in  4  new duration in ticks, 1..15.
- Rm, Ym, Gm  out  1 each  main-road red, yellow and green lamps.
- Rs, Ys, Gs  out  1 each  side-road red, yellow and green lamps.
- W  out  1  walk lamp.

## Operation
- **Timing registers** are 4 bits each. Reset values: tBASE = 6, tEXT = 3, tYEL = 2.
- **Reprogram write.** On each clock with reprogram = 1, extTimeValue is written into the selected register.
  - A value of 0 or selector 11 leaves all registers unchanged.
  - Every reprogram cycle also forces the FSM to MG1, reloads its timer, and clears the tick divider. The walk latch is untouched.
- **States, in order.** Each state lists its duration, then its lamps.
  - MG1: tBASE. Gm, Rs.
  - MG2: tEXT if sensor = 1 on the entry cycle, else tBASE. Gm, Rs.
  - MY: tYEL. Ym, Rs.
  - WALK: tEXT. Rm, Rs, W. Entered from MY only when the walk latch is set; otherwise MY goes to SG.
  - SG: tBASE, extended once by tEXT if sensor = 1 when tBASE expires. Rm, Gs.
  - SY: tYEL. Rm, Ys. Then back to MG1.
- **Lamp invariant.** Exactly one of Rm/Ym/Gm is high and exactly one of Rs/Ys/Gs is high. W is high only in WALK.
- **Walk latch.** Set on any cycle with walkRequest = 1. Cleared on the cycle WALK is entered. A request arriving during WALK is latched again and served in the next cycle of the sequence.
- **Timer.** On state entry the timer loads (duration − 1). It decrements on each tick. On a tick with timer = 0, the FSM advances.
- **Lamp decoding.** Outputs are decoded combinationally from the state register only; no input reaches an output combinationally.

## Timing
- **Reset** (reset low, asynchronous): state MG1, timer loaded with tBASE − 1, divider 0, walk latch 0, registers at default values.
  - Outputs during reset: Gm = 1, Rs = 1, all others 0.
- **Tick divider:** free-running, cleared only by reset and reprogram. The tick pulses for 1 cycle every TICK_DIV clocks.
- **State duration with TICK_DIV = 1:** exactly N clock cycles.
  - Default cycle with no sensor and no walk: 6 + 6 + 2 + 6 + 2 = 22 cycles.
- **Mid-phase register changes:** a change to a timing register during a phase takes effect at the next state entry. The exception is reprogram, which restarts the sequence at MG1 immediately.
- **Sensor sampling:** sensor is sampled only on MG2 entry and at SG tBASE expiry. Toggling it at any other time has no effect.
- **Simultaneous walkRequest and WALK entry:** the latch is set (set wins over clear).

## Structure
- Shared package `traffic_pkg` holds:
  - a state enum (MG1, MG2, MY, WALK, SG, SY);
  - selector constants SEL_BASE = 2'b00, SEL_EXT = 2'b01, SEL_YEL = 2'b10;
  - default durations 6, 3, 2.
- Sub-module `tick_timer` contains the divider plus the 4-bit loadable down-counter. It has two outputs:
  - `tick`: the one-cycle timebase pulse.
  - `expired`: high on a tick with count = 0.
- The top level holds the FSM, the timing registers, the walk latch and the lamp decode.

## Test plan
- **Default sequence.** TICK_DIV = 1; release reset; sensor = 0 and walkRequest = 0.
  - Required: Gm high for 12 cycles, Ym for 2, Gs for 6, Ys for 2, then Gm again (period 22).
  - Required: W never asserts, and the lamp invariant holds every cycle.
- **Sensor.** Hold sensor = 1 throughout.
  - Required: main green lasts 6 + 3 = 9 cycles and side green 6 + 3 = 9 cycles.
- **Walk.** Pulse walkRequest for 1 cycle during MG1.
  - Required: after MY, W = 1 with Rm = 1 and Rs = 1 for 3 cycles, then SG.
  - Required: the next sequence cycle has no WALK phase.
- **Reprogram.** Pulse reprogram with selector 00 and value 4, then with selector 10 and value 1.
  - Required: the sequence restarts at MG1, and main green = 8, yellow = 1, side green = 4.
  - Required: a write with value 0 or selector 11 leaves the durations unchanged.
- **Asynchronous reset mid-SG.** Drive reset low with no clock edge.
  - Required: outputs go immediately to Gm = 1, Rs = 1.
  - Required: timing registers return to 6/3/2 and the walk latch clears.
- **Divider.** TICK_DIV = 4.
  - Required: every state duration scales ×4 (MY = 8 clocks with tYEL = 2).
